// File: rtl/instr_memory_access.sv
// instr_memory_access: memory stage with a three-state data-memory handshake and load/store lane steering.
// Optional macro MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them down.
module instr_memory_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] store_data_in,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_trap
);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t state, state_nx;
    logic [6:0] in_opc;
    logic [2:0] in_f3, f3;
    logic [4:0] in_rd, rd;
    logic [31:0] addr, sdata, shifted, ext;
    logic [1:0] off, sh;
    logic ld, in_load, in_store, in_mem, in_alu, in_mis, accept, load_done, unused_bits;
    assign in_opc = instruction_in[6:0];
    assign in_f3 = instruction_in[14:12];
    assign in_rd = instruction_in[11:7];
    assign unused_bits = ^instruction_in[31:15];
    assign in_load = in_opc == OPC_LOAD && in_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign in_store = in_opc == OPC_STORE && in_f3 inside {3'b000, 3'b001, 3'b010};
    assign in_mem = in_load || in_store;
    assign in_alu = in_opc inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    assign accept = in_valid && state == IDLE;
`ifdef MISALIGN_TRAP_EN
    logic trap_q;
    assign in_mis = in_mem && (in_f3[1:0] == 2'b01 ? alu_in[0] : in_f3[1:0] == 2'b10 && alu_in[1:0] != 2'b00);
    assign misalign_trap = trap_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) trap_q <= 1'b0;
        else trap_q <= accept && in_mis;
`else
    assign in_mis = 1'b0;
    assign misalign_trap = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept && in_mem && !in_mis) state_nx = REQ;
        else if (state == REQ && dmem_gnt) state_nx = (ld && !dmem_rvalid) ? RSP : IDLE;
        else if (state == RSP && dmem_rvalid) state_nx = IDLE;
    end
    assign load_done = ld && dmem_rvalid && ((state == REQ && dmem_gnt) || state == RSP);
    assign stall_out = state != IDLE;
    assign off = addr[1:0];
    assign dmem_req = state == REQ;
    assign dmem_we = !ld;
    assign dmem_addr = {addr[31:2], 2'b00};
    assign dmem_be = f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign dmem_wdata = f3[1:0] == 2'b00 ? {4{sdata[7:0]}} : f3[1:0] == 2'b01 ? {2{sdata[15:0]}} : sdata;
    // Halves and words ignore the low offset bits, so misaligned accesses read the aligned container.
    assign sh = f3[1:0] == 2'b00 ? off : f3[1:0] == 2'b01 ? {off[1], 1'b0} : 2'b00;
    assign shifted = dmem_rdata >> {sh, 3'b000};
    assign ext = f3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                 f3 == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                 f3 == 3'b100 ? {24'd0, shifted[7:0]} :
                 f3 == 3'b101 ? {16'd0, shifted[15:0]} : shifted;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ld <= 1'b0;
            f3 <= '0;
            rd <= '0;
            addr <= '0;
            sdata <= '0;
            wb_valid <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                ld <= in_load;
                f3 <= in_f3;
                rd <= in_rd;
                addr <= alu_in;
                sdata <= store_data_in;
            end
            if (accept && in_alu && in_rd != 5'd0) begin
                wb_valid <= 1'b1;
                wb_rd <= in_rd;
                wb_data <= alu_in;
            end
            if (load_done && rd != 5'd0) begin
                wb_valid <= 1'b1;
                wb_rd <= rd;
                wb_data <= ext;
            end
        end
endmodule

// File: tb/tb_instr_memory_access.sv
// tb_instr_memory_access: vector table, reset corner sequences and random transactions against a size/offset model.
module tb_instr_memory_access;
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011, OPIMM = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011, SYS = 7'b1110011;

    typedef struct { logic [31:0] instr, alu, sd, rdata; int gd, rdly; } stim_t;
    typedef struct { logic trap, req, we, wbv, bad, stall; logic [31:0] addr, wdata, wbd; logic [3:0] be; logic [4:0] wbrd; } res_t;
    typedef struct { stim_t s; res_t e; } vec_t;

    logic clk = 0, rst = 1, in_valid = 0, dmem_gnt = 0, dmem_rvalid = 0;
    logic [31:0] instruction_in = 0, alu_in = 0, store_data_in = 0, dmem_rdata = 0;
    logic stall_out, dmem_req, dmem_we, wb_valid, misalign_trap;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0] dmem_be;
    logic [4:0] wb_rd;
    int total = 0, passed = 0;
    vec_t tbl[15];
    logic [6:0] opcs[14];

    instr_memory_access dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_in(instruction_in),
        .alu_in(alu_in), .store_data_in(store_data_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mk(logic [6:0] opc, logic [2:0] f3, logic [4:0] rd);
        return {17'd0, f3, rd, opc};
    endfunction

    function automatic vec_t mkv(logic [31:0] instr, alu, sd, rdata, int gd, rdly, logic req, logic [31:0] addr,
                                 logic [3:0] be, logic [31:0] wdata, logic we, wbv, logic [31:0] wbd, logic trap);
        vec_t v;
        v.s = '{instr, alu, sd, rdata, gd, rdly};
        v.e = '{default: '0};
        v.e.req = req; v.e.addr = addr; v.e.be = be; v.e.wdata = wdata; v.e.we = we;
        v.e.wbv = wbv; v.e.wbd = wbd; v.e.wbrd = instr[11:7]; v.e.trap = trap;
        return v;
    endfunction

    // Reference: access size from funct3, container offset = offset rounded down to the size.
    function automatic res_t model(stim_t s);
        res_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [4:0] rd;
        logic ld, st;
        int size, off, aoff;
        logic [63:0] v;
        e = '{default: '0};
        opc = s.instr[6:0]; f3 = s.instr[14:12]; rd = s.instr[11:7];
        ld = opc == LOAD && f3 != 3 && f3 != 6 && f3 != 7;
        st = opc == STORE && f3 < 3;
        if (opc == OP || opc == OPIMM || opc == LUI || opc == AUIPC || opc == JAL || opc == JALR) begin
            e.wbv = rd != 0; e.wbd = s.alu; e.wbrd = rd;
            return e;
        end
        if (!(ld || st)) return e;
        size = 1 << f3[1:0];
        off = int'(s.alu[1:0]);
`ifdef MISALIGN_TRAP_EN
        if (off % size != 0) begin
            e.trap = 1;
            return e;
        end
`endif
        aoff = off - off % size;
        e.req = 1; e.we = st; e.addr = s.alu & 32'hFFFF_FFFC;
        e.be = 4'(((1 << size) - 1) << aoff);
        e.wdata = size == 1 ? s.sd[7:0] * 32'h0101_0101 : size == 2 ? s.sd[15:0] * 32'h0001_0001 : s.sd;
        if (ld) begin
            v = ({32'd0, s.rdata} >> (8 * aoff)) & ((64'd1 << (8 * size)) - 1);
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v - (64'd1 << (8 * size));
            e.wbv = rd != 0; e.wbd = v[31:0]; e.wbrd = rd;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cmp(string tag, res_t o, res_t e);
        chk({tag, ".trap"}, o.trap, e.trap);
        chk({tag, ".req"}, o.req, e.req);
        if (e.req) begin
            chk({tag, ".addr"}, o.addr, e.addr);
            chk({tag, ".be"}, o.be, e.be);
            chk({tag, ".we"}, o.we, e.we);
            if (e.we) chk({tag, ".wdata"}, o.wdata, e.wdata);
            chk({tag, ".hold"}, o.bad, 0);
        end
        chk({tag, ".wb_valid"}, o.wbv, e.wbv);
        if (e.wbv) begin
            chk({tag, ".wb_data"}, o.wbd, e.wbd);
            chk({tag, ".wb_rd"}, o.wbrd, e.wbrd);
        end
        chk({tag, ".stall_after"}, o.stall, 0);
    endtask

    // One transaction: gd wait cycles before grant, rvalid rdly cycles after grant (0 = same cycle).
    // Junk rvalid and in_valid are driven wherever the block must ignore them.
    task automatic run(input stim_t s, output res_t o);
        o = '{default: '0};
        instruction_in = s.instr; alu_in = s.alu; store_data_in = s.sd; in_valid = 1;
        dmem_rvalid = 1; dmem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        in_valid = 0; dmem_rvalid = 0;
        o.trap = misalign_trap; o.req = dmem_req; o.wbv = wb_valid; o.wbd = wb_data; o.wbrd = wb_rd;
        if (dmem_req) begin
            o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
            for (int i = 0; i < s.gd; i++) begin
                in_valid = 1; instruction_in = mk(OPIMM, 0, 1); dmem_rvalid = 1;
                @(negedge clk);
                if (!dmem_req || !stall_out || wb_valid || dmem_addr !== o.addr || dmem_be !== o.be ||
                    dmem_wdata !== o.wdata || dmem_we !== o.we) o.bad = 1;
            end
            dmem_gnt = 1; dmem_rvalid = !o.we && s.rdly == 0; dmem_rdata = s.rdata;
            @(negedge clk);
            dmem_gnt = 0; dmem_rvalid = 0;
            if (!o.we && s.rdly > 0) begin
                for (int i = 0; i < s.rdly; i++) begin
                    if (dmem_req || !stall_out || wb_valid) o.bad = 1;
                    in_valid = 1; instruction_in = mk(OPIMM, 0, 1);
                    dmem_rvalid = i == s.rdly - 1; dmem_rdata = s.rdata;
                    @(negedge clk);
                end
                dmem_rvalid = 0;
            end
            in_valid = 0;
            o.wbv = wb_valid; o.wbd = wb_data; o.wbrd = wb_rd;
        end
        o.stall = stall_out;
    endtask

    initial begin
        res_t o;
        stim_t s;
        opcs = '{LOAD, LOAD, LOAD, STORE, STORE, STORE, OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, SYS};
        tbl[0]  = mkv(mk(OPIMM, 0, 5), 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
        tbl[1]  = mkv(mk(STORE, 0, 0), 32'h103, 32'hAB, 0, 2, 0, 1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1, 0, 0, 0);
        tbl[2]  = mkv(mk(LOAD, 0, 7), 32'h202, 0, 32'h0080_0000, 0, 0, 1, 32'h200, 4'b0100, 0, 0, 1, 32'hFFFF_FF80, 0);
        tbl[3]  = mkv(mk(LOAD, 4, 7), 32'h202, 0, 32'h0080_0000, 0, 0, 1, 32'h200, 4'b0100, 0, 0, 1, 32'h0000_0080, 0);
        tbl[4]  = mkv(mk(LOAD, 2, 3), 32'h40, 0, 32'hDEAD_BEEF, 0, 4, 1, 32'h40, 4'b1111, 0, 0, 1, 32'hDEAD_BEEF, 0);
        tbl[5]  = mkv(mk(BRANCH, 0, 5), 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(mk(OPIMM, 0, 0), 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mkv(mk(STORE, 2, 0), 32'h10, 32'h1234_5678, 0, 1, 0, 1, 32'h10, 4'b1111, 32'h1234_5678, 1, 0, 0, 0);
        tbl[8]  = mkv(mk(STORE, 1, 0), 32'h22, 32'h1234_BEEF, 0, 0, 0, 1, 32'h20, 4'b1100, 32'hBEEF_BEEF, 1, 0, 0, 0);
        tbl[9]  = mkv(mk(LOAD, 1, 9), 32'h6, 0, 32'h8001_0000, 1, 2, 1, 32'h4, 4'b1100, 0, 0, 1, 32'hFFFF_8001, 0);
        tbl[10] = mkv(mk(LOAD, 5, 9), 32'h6, 0, 32'h8001_0000, 1, 2, 1, 32'h4, 4'b1100, 0, 0, 1, 32'h0000_8001, 0);
        tbl[11] = mkv(mk(LOAD, 3, 4), 32'h8, 0, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        tbl[12] = mkv(mk(LOAD, 2, 3), 32'h101, 0, 32'hCAFE_F00D, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
`else
        tbl[12] = mkv(mk(LOAD, 2, 3), 32'h101, 0, 32'hCAFE_F00D, 0, 1, 1, 32'h100, 4'b1111, 0, 0, 1, 32'hCAFE_F00D, 0);
`endif
        tbl[13] = mkv(mk(LUI, 0, 31), 32'hABCD_E000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD_E000, 0);
        tbl[14] = mkv(mk(STORE, 0, 0), 32'h100, 32'h5A, 0, 0, 0, 1, 32'h100, 4'b0001, 32'h5A5A_5A5A, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst.req", dmem_req, 0);
        chk("rst.wb_valid", wb_valid, 0);
        chk("rst.trap", misalign_trap, 0);
        chk("rst.stall", stall_out, 0);
        chk("rst.wb_rd", wb_rd, 0);
        chk("rst.wb_data", wb_data, 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run(tbl[i].s, o);
            cmp($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Reset while waiting in RSP, then a late rvalid.
        instruction_in = mk(LOAD, 2, 3); alu_in = 32'h80; in_valid = 1;
        @(negedge clk);
        in_valid = 0; dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        chk("rsp.stall", stall_out, 1);
        chk("rsp.req", dmem_req, 0);
        rst = 1;
        #1;
        chk("rsp_rst.req", dmem_req, 0);
        chk("rsp_rst.stall", stall_out, 0);
        chk("rsp_rst.wb_valid", wb_valid, 0);
        chk("rsp_rst.wb_data", wb_data, 0);
        @(negedge clk);
        rst = 0; dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 0;
        chk("late_rvalid.wb_valid", wb_valid, 0);
        chk("late_rvalid.stall", stall_out, 0);

        // Reset while requesting; a grant arriving afterwards must be ignored.
        instruction_in = mk(LOAD, 2, 6); alu_in = 32'h84; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        chk("req.req", dmem_req, 1);
        rst = 1;
        #1;
        chk("req_rst.req", dmem_req, 0);
        @(negedge clk);
        rst = 0; dmem_gnt = 1; dmem_rvalid = 1;
        @(negedge clk);
        dmem_gnt = 0; dmem_rvalid = 0;
        chk("late_gnt.wb_valid", wb_valid, 0);
        chk("late_gnt.req", dmem_req, 0);

        for (int i = 0; i < 300; i++) begin
            s.instr = $urandom;
            s.instr[6:0] = opcs[$urandom_range(0, 13)];
            if ($urandom_range(0, 7) == 0) s.instr[11:7] = 0;
            s.alu = $urandom; s.sd = $urandom; s.rdata = $urandom;
            s.gd = $urandom_range(0, 3); s.rdly = $urandom_range(0, 3);
            run(s, o);
            cmp($sformatf("rnd%0d", i), o, model(s));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_memory_access.md
INSTR_MEMORY_ACCESS -- requirements
Module: instr_memory_access

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  execute-stage result valid this cycle.
REQ-005 instruction_in  in  32  instruction from execute stage.
REQ-006 alu_in  in  32  ALU result; effective address for LOAD/STORE.
REQ-007 store_data_in  in  32  store data, low-aligned.
REQ-008 stall_out  out  1  upstream hold request.
REQ-009 dmem_req  out  1  data-memory request.
REQ-010 dmem_we  out  1  1 = write, 0 = read.
REQ-011 dmem_addr  out  32  word address, bits [1:0] forced to 0.
REQ-012 dmem_be  out  4  byte enables.
REQ-013 dmem_wdata  out  32  lane-shifted store data.
REQ-014 dmem_gnt  in  1  request accepted.
REQ-015 dmem_rvalid  in  1  read data valid.
REQ-016 dmem_rdata  in  32  read data.
REQ-017 wb_valid  out  1  one-cycle writeback pulse.
REQ-018 wb_rd  out  5  destination register, instruction[11:7].
REQ-019 wb_data  out  32  writeback value.
REQ-020 misalign_trap  out  1  one-cycle misaligned-access pulse.

Function
REQ-021 The FSM SHALL use three states: IDLE, REQ and RSP.
REQ-022 In IDLE with in_valid=1, the block SHALL accept the instruction and register the opcode, funct3, rd, alu_in and store_data_in.
REQ-023 A non-memory opcode (OP, OP_IMM, LUI, AUIPC, JAL, JALR) with rd!=0 SHALL produce wb_valid=1 and wb_data=alu_in on the next cycle, with no state change.
REQ-024 BRANCH, STORE and rd=0 instructions SHALL never assert wb_valid.
REQ-025 Accepting a LOAD or STORE SHALL move the FSM to REQ.
REQ-026 In REQ the block SHALL hold dmem_req=1 with dmem_addr, dmem_we, dmem_be and dmem_wdata stable until dmem_gnt=1.
REQ-027 STORE in REQ with dmem_gnt=1 SHALL return to IDLE.
REQ-028 LOAD in REQ with dmem_gnt=1 SHALL move to RSP; if dmem_rvalid=1 in the same cycle, the load SHALL complete immediately (same data path as REQ-030) and return to IDLE.
REQ-029 dmem_req SHALL be 0 in IDLE and RSP.
REQ-030 In RSP with dmem_rvalid=1, the block SHALL pulse wb_valid (if rd!=0) on the next cycle with extended data and return to IDLE.
REQ-031 dmem_rvalid SHALL be ignored in IDLE, and in REQ unless dmem_gnt=1.
REQ-032 stall_out SHALL be 1 exactly when the state is not IDLE; in_valid SHALL be ignored outside IDLE.
REQ-033 Byte lane SHALL be off = alu_in[1:0].
REQ-034 SB SHALL drive be=0001<<off with wdata = byte replicated x4.
REQ-035 SH SHALL drive be=0011<<off[1] x2 with wdata = half replicated x2.
REQ-036 SW SHALL drive be=1111 with wdata unchanged.
REQ-037 Loads SHALL shift rdata right by 8*off, then extend: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-038 Undefined funct3 for LOAD/STORE SHALL be treated as a no-op: no request, no writeback.

Reset
REQ-039 While rst=1, the block SHALL hold state=IDLE with dmem_req, wb_valid, misalign_trap and stall_out at 0, and wb_rd and wb_data at 0.
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction without further outputs; the memory side SHALL tolerate the abandoned request.

Configuration
REQ-041 The macro MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-042 With MISALIGN_TRAP_EN defined, LH/LHU/SH with off[0]=1 or LW/SW with off!=0 SHALL issue no request, pulse misalign_trap for one cycle on the next cycle, skip writeback and stay in IDLE.
REQ-043 Without MISALIGN_TRAP_EN, misalign_trap SHALL be tied to 0 and the access SHALL proceed using off[1] (half) or word alignment (word), with the low bits ignored.

Verification
REQ-044 ADDI x5 with alu_in=0x0000_0010 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x10, stall_out=0.
REQ-045 SB, alu_in=0x103, store_data=0xAB, gnt after 2 cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB held for 3 cycles, no wb_valid.
REQ-046 LB x7, alu_in=0x202, gnt+rvalid same cycle, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; repeated with LBU -> wb_data=0x0000_0080.
REQ-047 LW x3, gnt, rvalid 4 cycles later -> stall_out=1 throughout REQ/RSP, wb_data=rdata; next instruction accepted the cycle after return to IDLE.
REQ-048 rst=1 asserted in RSP -> dmem_req=0, wb_valid=0, state IDLE; a late rvalid after reset is ignored.
REQ-049 With MISALIGN_TRAP_EN defined, LW alu_in=0x101 -> misalign_trap pulses once, dmem_req stays 0; without the macro -> read at 0x100, be=1111.
